// File: rtl/handle_pool_pkg.sv
// Shared types and width helpers for the handle pool.
// State and error-code encodings used by pool logic.
package handle_pool_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_NOT_ALLOC = 2'd1,
    ERR_FAMILY    = 2'd2
  } err_t;

  localparam int DEF_NUM_HANDLES  = 16;
  localparam int DEF_NUM_FAMILIES = 4;
  localparam int ERR_W            = 2;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/handle_fifo.sv
// Circular-buffer free list of handle numbers.
// Push and pop may occur together; pop reads the head combinationally.
module handle_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import handle_pool_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage write at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap on power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/handle_pool.sv
// Free-list handle allocator with per-handle family ownership.
// Illegal releases are rejected and reported one cycle later.
module handle_pool #(
  parameter int NUM_HANDLES  = 16,
  parameter int NUM_FAMILIES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_valid,
  input  logic [$clog2(NUM_FAMILIES)-1:0]  alloc_family,
  output logic                             alloc_ready,
  output logic                             rsp_valid,
  output logic [$clog2(NUM_HANDLES)-1:0]   rsp_handle,
  input  logic                             free_valid,
  input  logic [$clog2(NUM_HANDLES)-1:0]   free_handle,
  input  logic [$clog2(NUM_FAMILIES)-1:0]  free_family,
  output logic                             free_ready,
  output logic                             err_valid,
  output logic [1:0]                       err_code,
  output logic [$clog2(NUM_HANDLES+1)-1:0] in_use
);
  import handle_pool_pkg::*;

  localparam int HW = $clog2(NUM_HANDLES);
  localparam int FW = $clog2(NUM_FAMILIES);
  localparam int CW = cnt_w(NUM_HANDLES);
  localparam logic [HW-1:0] LAST = HW'(NUM_HANDLES - 1);

  state_t          state;
  logic [HW-1:0]   init_cnt;
  logic [NUM_HANDLES-1:0] owned;
  logic [FW-1:0]   owner [NUM_HANDLES];
  err_t            err_q;

  logic            fifo_push;
  logic [HW-1:0]   fifo_wdata;
  logic [HW-1:0]   fifo_head;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;
  logic            unused_fifo;

  logic            alloc_fire;
  logic            free_fire;
  logic            free_legal;
  logic            free_ok;
  logic            free_bad;

  assign alloc_ready = (state == RUN) && !fifo_empty;
  assign free_ready  = (state == RUN);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign free_fire   = free_valid && free_ready;
  assign free_legal  = owned[free_handle] &&
                       (owner[free_handle] == free_family);
  assign free_ok     = free_fire && free_legal;
  assign free_bad    = free_fire && !free_legal;
  assign fifo_push   = (state == INIT) || free_ok;
  assign fifo_wdata  = (state == INIT) ? init_cnt : free_handle;
  assign err_code    = err_q;
  assign unused_fifo = ^{fifo_full, fifo_count};

  handle_fifo #(
    .DEPTH (NUM_HANDLES),
    .W     (HW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (alloc_fire),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Sequencer: seed the free list with ascending handles, then run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      unique case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Ownership table: set on grant, cleared on legal release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owned <= '0;
      for (int i = 0; i < NUM_HANDLES; i++) owner[i] <= '0;
    end else begin
      if (alloc_fire) begin
        owned[fifo_head] <= 1'b1;
        owner[fifo_head] <= alloc_family;
      end
      if (free_ok) owned[free_handle] <= 1'b0;
    end
  end

  // Registered grant response and release error report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_handle <= '0;
      err_valid  <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      rsp_valid <= alloc_fire;
      if (alloc_fire) rsp_handle <= fifo_head;
      err_valid <= free_bad;
      if (!free_bad)
        err_q <= ERR_NONE;
      else if (!owned[free_handle])
        err_q <= ERR_NOT_ALLOC;
      else
        err_q <= ERR_FAMILY;
    end
  end

  // Outstanding-handle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use <= '0;
    end else begin
      unique case ({alloc_fire, free_ok})
        2'b10:   in_use <= in_use + CW'(1);
        2'b01:   in_use <= in_use - CW'(1);
        default: in_use <= in_use;
      endcase
    end
  end

endmodule

// File: tb/tb_handle_pool.sv
// Directed bench for handle_pool with a queue-based reference model.
// Model is compared every cycle; literal checks pin key scenarios.
module tb_handle_pool;
  localparam int N  = 16;
  localparam int NF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [1:0] alloc_family = '0;
  logic       alloc_ready;
  logic       rsp_valid;
  logic [3:0] rsp_handle;
  logic       free_valid = 1'b0;
  logic [3:0] free_handle = '0;
  logic [1:0] free_family = '0;
  logic       free_ready;
  logic       err_valid;
  logic [1:0] err_code;
  logic [4:0] in_use;

  int checks = 0;
  int failures = 0;

  // reference model state
  int edges;
  int fq[$];
  bit m_owned [N];
  int m_owner [N];
  int m_inuse;
  bit x_rv;
  int x_rh;
  bit x_ev;
  int x_ec;

  always #5 clk = ~clk;

  handle_pool #(
    .NUM_HANDLES  (N),
    .NUM_FAMILIES (NF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_family (alloc_family),
    .alloc_ready  (alloc_ready),
    .rsp_valid    (rsp_valid),
    .rsp_handle   (rsp_handle),
    .free_valid   (free_valid),
    .free_handle  (free_handle),
    .free_family  (free_family),
    .free_ready   (free_ready),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .in_use       (in_use)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    fq.delete();
    for (int i = 0; i < N; i++) begin
      fq.push_back(i);
      m_owned[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_inuse = 0;
    x_rv = 1'b0;
    x_rh = 0;
    x_ev = 1'b0;
    x_ec = 0;
  endtask

  task automatic model_step();
    bit run;
    bit a_ok;
    bit f_ok;
    int h;
    int fh;
    run  = (edges >= N);
    a_ok = run && alloc_valid && (fq.size() > 0);
    f_ok = run && free_valid;
    fh   = int'(free_handle);
    x_ev = 1'b0;
    x_ec = 0;
    if (f_ok) begin
      if (!m_owned[fh]) begin
        x_ev = 1'b1;
        x_ec = 1;
      end else if (m_owner[fh] != int'(free_family)) begin
        x_ev = 1'b1;
        x_ec = 2;
      end
    end
    x_rv = a_ok;
    if (a_ok) begin
      h = fq.pop_front();
      x_rh = h;
      m_owned[h] = 1'b1;
      m_owner[h] = int'(alloc_family);
      m_inuse++;
    end
    if (f_ok && !x_ev) begin
      fq.push_back(fh);
      m_owned[fh] = 1'b0;
      m_inuse--;
    end
    if (edges < N) edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_alloc_ready", alloc_ready,
          (edges >= N) && (fq.size() > 0));
      chk("m_free_ready", free_ready, edges >= N);
      chk("m_rsp_valid", rsp_valid, x_rv);
      chk("m_rsp_handle", rsp_handle, x_rh);
      chk("m_err_valid", err_valid, x_ev);
      chk("m_err_code", err_code, x_ec);
      chk("m_in_use", in_use, m_inuse);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_in_use", in_use, 0);
    chk("rst_ready", alloc_ready, 0);
    chk("rst_rsp_handle", rsp_handle, 0);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      step();
      chk("init_ready", alloc_ready, (k == N - 1) ? 1 : 0);
    end
    chk("init_in_use", in_use, 0);

    alloc_valid = 1'b1;
    alloc_family = 2'd1;
    for (int i = 0; i < N; i++) begin
      step();
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_rsp_handle", rsp_handle, i);
    end
    chk("full_ready", alloc_ready, 0);
    chk("full_in_use", in_use, 16);
    alloc_valid = 1'b0;

    free_valid = 1'b1;
    free_handle = 4'd5;
    free_family = 2'd1;
    step();
    free_valid = 1'b0;
    chk("free5_in_use", in_use, 15);
    chk("free5_err", err_valid, 0);
    chk("free5_ready", alloc_ready, 1);
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    chk("realloc_rsp", rsp_handle, 5);
    chk("realloc_in_use", in_use, 16);

    free_valid = 1'b1;
    step();
    chk("dbl1_in_use", in_use, 15);
    step();
    chk("dbl2_err_valid", err_valid, 1);
    chk("dbl2_err_code", err_code, 1);
    chk("dbl2_in_use", in_use, 15);
    free_handle = 4'd3;
    free_family = 2'd2;
    step();
    chk("fam_err_valid", err_valid, 1);
    chk("fam_err_code", err_code, 2);
    chk("fam_in_use", in_use, 15);
    free_valid = 1'b0;
    step();
    chk("idle_err_valid", err_valid, 0);
    chk("idle_err_code", err_code, 0);

    alloc_valid = 1'b1;
    step();
    chk("drain_rsp", rsp_handle, 5);
    chk("drain_ready", alloc_ready, 0);
    free_valid = 1'b1;
    free_handle = 4'd7;
    free_family = 2'd1;
    step();
    free_valid = 1'b0;
    chk("sim_no_rsp", rsp_valid, 0);
    chk("sim_ready", alloc_ready, 1);
    chk("sim_in_use", in_use, 15);
    step();
    alloc_valid = 1'b0;
    chk("sim_rsp_valid", rsp_valid, 1);
    chk("sim_rsp_handle", rsp_handle, 7);
    chk("sim_in_use2", in_use, 16);

    free_valid = 1'b1;
    free_handle = 4'd3;
    free_family = 2'd1;
    step();
    chk("own3_err", err_valid, 0);
    chk("own3_in_use", in_use, 15);
    for (int h = 8; h < 14; h++) begin
      free_handle = 4'(h);
      step();
    end
    free_valid = 1'b0;
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    chk("pre_rst_rsp", rsp_valid, 1);
    chk("pre_rst_handle", rsp_handle, 3);
    chk("pre_rst_in_use", in_use, 10);

    #1 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_handle", rsp_handle, 0);
    chk("arst_ready", alloc_ready, 0);
    chk("arst_free_ready", free_ready, 0);
    chk("arst_in_use", in_use, 0);
    chk("arst_err", err_valid, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) step();
    chk("reinit_ready", alloc_ready, 1);
    alloc_valid = 1'b1;
    alloc_family = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reinit_rsp", rsp_handle, i);
    end
    alloc_valid = 1'b0;
    free_valid = 1'b1;
    free_handle = 4'd4;
    free_family = 2'd1;
    step();
    free_valid = 1'b0;
    chk("stale_err_valid", err_valid, 1);
    chk("stale_err_code", err_code, 1);
    chk("stale_in_use", in_use, 3);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handle_pool.md
# handle_pool

Synthesizable free-list allocator that hands out numbered object handles tagged with a product-family ID. It recycles handles on release. It is the consumer and recycler end of the factory flow: a creator requests a handle for a family, and a destroyer returns it. The block sits between request-generating stimulus and any handle-indexed storage. It tracks ownership so illegal releases are caught in hardware.

## Interface
- NUM_HANDLES, 16, number of handles in the pool; power of two, ≥2
- NUM_FAMILIES, 4, number of distinct family IDs; ≥2
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- alloc_valid  in  1  allocate request
- alloc_family  in  FW=$clog2(NUM_FAMILIES)  family of requested handle
- alloc_ready  out  1  request accepted when alloc_valid && alloc_ready
- rsp_valid  out  1  one-cycle pulse carrying the granted handle
- rsp_handle  out  HW=$clog2(NUM_HANDLES)  granted handle
- free_valid  in  1  release request
- free_handle  in  HW  handle being released
- free_family  in  FW  family the releaser believes owns it
- free_ready  out  1  release accepted when free_valid && free_ready
- err_valid  out  1  one-cycle pulse on an illegal release
- err_code  out  2  0=none, 1=not allocated, 2=family mismatch
- in_use  out  $clog2(NUM_HANDLES+1)  count of allocated handles

## Operation
- State machine with two states, INIT and RUN.
  - On rst, the block enters INIT and the init counter clears.
  - INIT pushes handles 0..NUM_HANDLES-1 into the free list, one per cycle.
  - After the last push, the block moves to RUN. It stays in RUN until rst.
- alloc_ready = RUN && free list not empty. It is combinational from state and count and never depends on alloc_valid.
- free_ready = RUN.
- Accepted alloc:
  - pop the free-list head;
  - set owned[h] and owner[h]=alloc_family;
  - in_use increments.
- Accepted free, legal case (owned[h] && owner[h]==free_family):
  - push h to the free-list tail;
  - clear owned[h];
  - in_use decrements.
- Accepted free, illegal cases: the handle is not pushed and no state changes.
  - If !owned[h], err_code=1.
  - If owned but the owner differs, err_code=2.
  - In both cases err_valid pulses.
- Simultaneous legal alloc and free in one cycle:
  - both take effect;
  - in_use is unchanged;
  - a handle freed this cycle is not bypassed to the alloc. alloc_ready is evaluated from the pre-cycle count, so an empty pool stays not-ready that cycle.
- Simultaneous alloc and free of the same handle cannot occur, because a handle is never free and owned at the same time.
- Free-list order is FIFO. Initial order is ascending.

## Timing
- Reset values:
  - alloc_ready=0, free_ready=0, rsp_valid=0, rsp_handle=0;
  - err_valid=0, err_code=0, in_use=0;
  - all owned bits cleared.
- INIT lasts exactly NUM_HANDLES cycles after rst deasserts. alloc_ready first rises on cycle NUM_HANDLES, counting from the first edge after deassert as 0.
- Alloc latency is 1 cycle: rsp_valid and rsp_handle are registered and appear the cycle after acceptance. Back-to-back accepts give back-to-back responses.
- Release takes effect 1 cycle after acceptance. The freed handle is allocatable from the following cycle.
- err_valid and err_code are registered and appear 1 cycle after the offending accept. err_code returns to 0 when err_valid is low.
- in_use updates 1 cycle after acceptance.
- rst asserted mid-operation:
  - all outstanding handles are forgotten;
  - any pending rsp_valid or err_valid is killed immediately;
  - the block re-enters INIT.
- Requests presented while ready is low are ignored. No error is raised for them.

## Structure
- handle_pool_pkg holds:
  - the state enum (INIT, RUN);
  - the err_code enum (ERR_NONE, ERR_NOT_ALLOC, ERR_FAMILY);
  - width helper constants.
- One sub-module, handle_fifo, implements the free list as a circular buffer:
  - depth NUM_HANDLES, width HW;
  - wrapping read and write pointers and a count;
  - push and pop allowed in the same cycle;
  - full and empty flags.
- The ownership arrays owned[NUM_HANDLES] and owner[NUM_HANDLES] live in handle_pool.

## Test plan
- Reset with defaults: alloc_ready stays 0 for 16 cycles and rises on cycle 16. in_use=0.
- 16 back-to-back allocs with family 1: rsp_handle is 0,1,…,15 on consecutive cycles, in_use=16, and alloc_ready=0 on the 17th cycle.
- With all 16 allocated, free handle 5 with family 1, then alloc: rsp_handle=5 and in_use returns to 16.
- Free handle 5 twice: the second free gives err_valid pulse with err_code=1 and in_use is unchanged. Free handle 3, owned by family 1, with family 2: err_code=2, and handle 3 remains allocated.
- With the pool empty, assert alloc and a legal free of handle 7 in the same cycle:
  - the alloc is not accepted;
  - on the next cycle alloc_ready=1 and the alloc returns 7.
- Assert rst with 10 handles outstanding and rsp_valid pending:
  - outputs return to reset values at once;
  - after 16 INIT cycles, allocs again return 0,1,2… and freeing old handle 4 gives err_code=1.
